// File: rtl/tinytpu_pkg.sv
// Shared types and sizing helpers for the tinytpu sequencer.
//
// Contents:
//   state_e   sequencer FSM states
//   word_cyc  valid cycles needed to deserialise one operand word
//   out_cyc   lane groups emitted per result word (one more when TINYTPU_PARITY_EN is defined)
//   feed_len  cycles of skewed operand feed into the N x N core
//
// Build option: TINYTPU_PARITY_EN appends a parity group after every result word.
package tinytpu_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

  localparam int unsigned D_W_DEF      = 8;
  localparam int unsigned N_DEF        = 2;
  localparam int unsigned K_DEF        = 2;
  localparam int unsigned LANES_DEF    = 1;
  localparam int unsigned PIPE_LAT_DEF = 1;

  function automatic int unsigned word_cyc(input int unsigned d_w, input int unsigned lanes);
    return d_w / lanes;
  endfunction

  function automatic int unsigned out_cyc(input int unsigned d_w, input int unsigned lanes);
`ifdef TINYTPU_PARITY_EN
    return (2 * d_w) / lanes + 1;
`else
    return (2 * d_w) / lanes;
`endif
  endfunction

  function automatic int unsigned feed_len(input int unsigned n, input int unsigned k);
    return k + 2 * n - 1;
  endfunction

  localparam int unsigned WORD_CYC = word_cyc(D_W_DEF, LANES_DEF);
  localparam int unsigned OUT_CYC  = out_cyc(D_W_DEF, LANES_DEF);
  localparam int unsigned FEED_LEN = feed_len(N_DEF, K_DEF);

endpackage

// File: rtl/tinytpu_seq_ctrl_if.sv
// Serial pin bundle of the tinytpu sequencer.
//
// Signals:
//   start        begin a frame (honoured only while idle)
//   in_valid     data_in_x / data_in_y carry LANES valid bits, MSB-first
//   data_in_x/y  operand bits; lane LANES-1 is the most significant
//   data_out_z   result bits, MSB-first
//   out_valid    data_out_z valid
//   out_ready    sink accepts the current group
//   busy         sequencer not idle
//   done         one-cycle pulse at frame end
// Modports: master = pin driver / result sink, slave = sequencer.
interface tinytpu_seq_ctrl_if #(
  parameter int unsigned LANES = 1
);
  logic             start;
  logic             in_valid;
  logic [LANES-1:0] data_in_x;
  logic [LANES-1:0] data_in_y;
  logic [LANES-1:0] data_out_z;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, data_in_x, data_in_y, out_ready,
    input  data_out_z, out_valid, busy, done
  );

  modport slave (
    input  start, in_valid, data_in_x, data_in_y, out_ready,
    output data_out_z, out_valid, busy, done
  );
endinterface

// File: rtl/tinytpu_deser.sv
// LANES-wide MSB-first deserialiser for one operand port.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   clr        synchronous clear of shift register and bit counter
//   shift_en   take 'bits' this cycle
//   bits       incoming lanes; lane LANES-1 is the more significant
//   word       shift register contents including this cycle's bits
//   word_done  high on the cycle the final group of a word arrives; 'word' is then complete
module tinytpu_deser
  import tinytpu_pkg::*;
#(
  parameter int unsigned D_W   = D_W_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [LANES-1:0] bits,
  output logic [D_W-1:0]   word,
  output logic             word_done
);
  localparam int unsigned WordCyc = word_cyc(D_W, LANES);
  localparam int unsigned CntW    = (WordCyc > 1) ? $clog2(WordCyc) : 1;

  logic [D_W-1:0]       sr_q;
  logic [CntW-1:0]      cnt_q;
  logic [D_W+LANES-1:0] cat;

  assign cat       = {sr_q, bits};
  assign word      = cat[D_W-1:0];
  assign word_done = shift_en && (cnt_q == CntW'(WordCyc - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= word;
      cnt_q <= word_done ? '0 : cnt_q + CntW'(1);
    end
  end
endmodule

// File: rtl/tinytpu_seq_ctrl.sv
// Sequencer between the serial pins and the N x N systolic core.
// Loads X (N x K) and Y (K x N) serially, feeds them skewed into the core, waits PIPE_LAT
// cycles, snapshots z_flat and streams the N*N results out with a valid/ready handshake.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   pins        serial pin bundle (tinytpu_seq_ctrl_if.slave)
//   x_flat      row feeds, row i at [i*D_W +: D_W]
//   y_flat      column feeds, column j at [j*D_W +: D_W]
//   core_init   clears the core accumulators
//   z_flat      core results, Z[i][j] at [(i*N+j)*2*D_W +: 2*D_W]
//
// Build option: TINYTPU_PARITY_EN appends one group per result word whose lane 0 is the
// XOR of the word's bits.
module tinytpu_seq_ctrl
  import tinytpu_pkg::*;
#(
  parameter int unsigned D_W      = D_W_DEF,
  parameter int unsigned N        = N_DEF,
  parameter int unsigned K        = K_DEF,
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  tinytpu_seq_ctrl_if.slave      pins,
  output logic [N*D_W-1:0]       x_flat,
  output logic [N*D_W-1:0]       y_flat,
  output logic                   core_init,
  input  logic [N*N*2*D_W-1:0]   z_flat
);
  localparam int unsigned ZW      = 2 * D_W;
  localparam int unsigned DataCyc = ZW / LANES;
  localparam int unsigned OutCyc  = out_cyc(D_W, LANES);
  localparam int unsigned FeedLen = feed_len(N, K);
  localparam int unsigned Words   = N * K;
  localparam int unsigned CmpEnd  = FeedLen + PIPE_LAT;
  localparam int unsigned CntW    = $clog2(CmpEnd + OutCyc + 1);
  localparam int unsigned LdW     = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned ZwW     = (N * N > 1) ? $clog2(N * N) : 1;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;      // compute cycle, or group within the current result word
  logic [LdW-1:0]       ld_idx_q;
  logic [ZwW-1:0]       zw_idx_q;
  logic [D_W-1:0]       xbuf_q [Words];
  logic [D_W-1:0]       ybuf_q [Words];
  logic [N*N*ZW-1:0]    z_sh_q;
  logic [LANES-1:0]     dout_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 done_q;

  logic [D_W-1:0]       x_word, y_word;
  logic                 x_done, y_done;
  logic                 shift_en, deser_clr;
  logic [N*D_W-1:0]     x_feed, y_feed;
  logic                 last_grp;
  logic [CntW-1:0]      cnt_nx;
  logic [ZwW-1:0]       zw_nx;

  assign shift_en  = (state_q == LOAD) && pins.in_valid;
  assign deser_clr = (state_q != LOAD);

  tinytpu_deser #(.D_W(D_W), .LANES(LANES)) u_deser_x (
    .clk       (clk),
    .rst       (rst),
    .clr       (deser_clr),
    .shift_en  (shift_en),
    .bits      (pins.data_in_x),
    .word      (x_word),
    .word_done (x_done)
  );

  tinytpu_deser #(.D_W(D_W), .LANES(LANES)) u_deser_y (
    .clk       (clk),
    .rst       (rst),
    .clr       (deser_clr),
    .shift_en  (shift_en),
    .bits      (pins.data_in_y),
    .word      (y_word),
    .word_done (y_done)
  );

  // Feeds for skew step t = cnt_q (registered, so they appear in compute cycle cnt_q+1).
  // Row i carries X[i][k] at t = i+k; column j carries Y[k][j] at t = j+k.
  always_comb begin
    x_feed = '0;
    y_feed = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K; k++) begin
        if (int'(cnt_q) == i + k) x_feed[i*D_W +: D_W] = xbuf_q[i*K + k];
      end
    end
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < K; k++) begin
        if (int'(cnt_q) == j + k) y_feed[j*D_W +: D_W] = ybuf_q[k*N + j];
      end
    end
  end

  always_comb begin
    last_grp = (cnt_q == CntW'(OutCyc - 1));
    cnt_nx   = last_grp ? '0 : cnt_q + CntW'(1);
    zw_nx    = last_grp ? zw_idx_q + ZwW'(1) : zw_idx_q;
  end

  // Lane group g of result word w; groups past the data bits carry the parity group.
  function automatic logic [LANES-1:0] pick_group(input logic [N*N*ZW-1:0] z,
                                                  input int unsigned w, input int unsigned g);
    logic [ZW-1:0] zword;
    zword      = z[w*ZW +: ZW];
    pick_group = '0;
    if (g < DataCyc) begin
      pick_group = zword[(DataCyc-1-g)*LANES +: LANES];
    end
`ifdef TINYTPU_PARITY_EN
    else begin
      pick_group[0] = ^zword;
    end
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_idx_q    <= '0;
      zw_idx_q    <= '0;
      x_flat      <= '0;
      y_flat      <= '0;
      core_init   <= 1'b0;
      z_sh_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int w = 0; w < Words; w++) begin
        xbuf_q[w] <= '0;
        ybuf_q[w] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pins.start) begin
            state_q  <= LOAD;
            busy_q   <= 1'b1;
            ld_idx_q <= '0;
            cnt_q    <= '0;
          end
        end
        LOAD: begin
          if (x_done && y_done) begin
            xbuf_q[ld_idx_q] <= x_word;
            ybuf_q[ld_idx_q] <= y_word;
            if (ld_idx_q == LdW'(Words - 1)) begin
              state_q   <= COMPUTE;
              cnt_q     <= '0;
              core_init <= 1'b1;
            end else begin
              ld_idx_q <= ld_idx_q + LdW'(1);
            end
          end
        end
        COMPUTE: begin
          core_init <= 1'b0;
          if (cnt_q == CntW'(CmpEnd)) begin
            // Last pipeline idle cycle: the core result is final, so snapshot it.
            state_q     <= DRAIN;
            z_sh_q      <= z_flat;
            x_flat      <= '0;
            y_flat      <= '0;
            cnt_q       <= '0;
            zw_idx_q    <= '0;
            out_valid_q <= 1'b1;
            dout_q      <= pick_group(z_flat, 0, 0);
          end else begin
            cnt_q  <= cnt_q + CntW'(1);
            x_flat <= x_feed;
            y_flat <= y_feed;
          end
        end
        DRAIN: begin
          if (out_valid_q && pins.out_ready) begin
            if (last_grp && (zw_idx_q == ZwW'(N * N - 1))) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              dout_q      <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              cnt_q       <= '0;
              zw_idx_q    <= '0;
            end else begin
              cnt_q    <= cnt_nx;
              zw_idx_q <= zw_nx;
              dout_q   <= pick_group(z_sh_q, 32'(zw_nx), 32'(cnt_nx));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pins.data_out_z = dout_q;
  assign pins.out_valid  = out_valid_q;
  assign pins.busy       = busy_q;
  assign pins.done       = done_q;
endmodule
